// File: rtl/max30102_fifo_sched.sv
// MAX30102 FIFO drain scheduler: on a level-low interrupt, reads status and
// FIFO pointers, then streams 6-byte {red, ir} samples out of the data register.
module max30102_fifo_sched (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        init_done,
    input  logic        intr,
    output logic        cmd_go,
    output logic        cmd_wr,
    output logic [7:0]  cmd_reg,
    output logic [7:0]  cmd_wdata,
    input  logic        cmd_busy,
    input  logic        cmd_done,
    input  logic [7:0]  cmd_rdata,
    input  logic        cmd_nack,
    output logic [35:0] sample_data,
    output logic        sample_valid,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    localparam int unsigned WDOG_W = 16;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned PTR_W  = 5;
    localparam int unsigned ACC_W  = 28;
    localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ST, S_RD_WP, S_RD_OVF, S_RD_RP, S_CALC, S_RD_DAT
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_sync1, r_sync2;
    logic               r_issued;
    logic [WDOG_W-1:0]  r_wdog;
    logic [PTR_W-1:0]   r_wp, r_rp;
    logic               r_ovf_nz;
    logic [CNT_W-1:0]   r_n;
    logic [2:0]         r_byte_idx;
    logic [ACC_W-1:0]   r_acc;
    logic               w_is_rd, w_issue, w_ok, w_abort;
    logic [7:0]         w_reg_addr;
    logic [PTR_W-1:0]   w_diff;

    // The engine only ever reads.
    assign cmd_wr    = 1'b0;
    assign cmd_wdata = 8'h00;

    // Next-state and transaction handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_ok        = 1'b0;
        w_abort     = 1'b0;
        w_reg_addr  = 8'h00;
        w_is_rd     = 1'b1;
        w_diff      = PTR_W'(r_wp - r_rp);

        case (r_state)
            S_RD_ST:  w_reg_addr = 8'h00;
            S_RD_WP:  w_reg_addr = 8'h04;
            S_RD_OVF: w_reg_addr = 8'h05;
            S_RD_RP:  w_reg_addr = 8'h06;
            S_RD_DAT: w_reg_addr = 8'h07;
            default:  w_is_rd    = 1'b0;
        endcase

        if (w_is_rd) begin
            if (!r_issued) begin
                w_issue = !cmd_busy;
            end else if (cmd_done) begin
                w_ok    = !cmd_nack;
                w_abort = cmd_nack;
            end else if (r_wdog == WDOG_MAX) begin
                w_abort = 1'b1;
            end
        end

        case (r_state)
            S_IDLE:   if (!r_sync2 && init_done) w_state_nxt = S_RD_ST;
            S_RD_ST:  if (w_ok) w_state_nxt = S_RD_WP;
            S_RD_WP:  if (w_ok) w_state_nxt = S_RD_OVF;
            S_RD_OVF: if (w_ok) w_state_nxt = S_RD_RP;
            S_RD_RP:  if (w_ok) w_state_nxt = S_CALC;
            S_CALC:   w_state_nxt = (w_diff != '0 || r_ovf_nz) ? S_RD_DAT : S_IDLE;
            S_RD_DAT: if (w_ok && r_byte_idx == 3'd5 && r_n == CNT_W'(1)) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase

        if (w_abort) w_state_nxt = S_IDLE;
    end

    // Two-flop synchroniser for the asynchronous interrupt; idles high (deasserted).
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= intr;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= S_IDLE;
            busy         <= 1'b0;
            cmd_go       <= 1'b0;
            cmd_reg      <= 8'h00;
            r_issued     <= 1'b0;
            r_wdog       <= '0;
            err_cnt      <= 8'h00;
            r_wp         <= '0;
            r_rp         <= '0;
            r_ovf_nz     <= 1'b0;
            r_n          <= '0;
            r_byte_idx   <= '0;
            r_acc        <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            busy         <= (w_state_nxt != S_IDLE);
            cmd_go       <= w_issue;
            sample_valid <= 1'b0;

            if (w_issue) begin
                cmd_reg  <= w_reg_addr;
                r_issued <= 1'b1;
            end else if (w_ok || w_abort) begin
                r_issued <= 1'b0;
            end

            // Watchdog runs only while a transaction is outstanding.
            if (!r_issued || cmd_done) r_wdog <= '0;
            else                       r_wdog <= r_wdog + WDOG_W'(1);

            if (w_abort && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

            if (r_state == S_CALC) begin
                r_n        <= (w_diff != '0) ? CNT_W'(w_diff) : CNT_W'(32);
                r_byte_idx <= '0;
            end

            if (w_ok) begin
                case (r_state)
                    S_RD_WP:  r_wp     <= cmd_rdata[PTR_W-1:0];
                    S_RD_OVF: r_ovf_nz <= |cmd_rdata[PTR_W-1:0];
                    S_RD_RP:  r_rp     <= cmd_rdata[PTR_W-1:0];
                    S_RD_DAT: begin
                        // Only 18 bits per channel: top six bits of each leading byte dropped.
                        case (r_byte_idx)
                            3'd0:    r_acc[27:26] <= cmd_rdata[1:0];
                            3'd1:    r_acc[25:18] <= cmd_rdata;
                            3'd2:    r_acc[17:10] <= cmd_rdata;
                            3'd3:    r_acc[9:8]   <= cmd_rdata[1:0];
                            3'd4:    r_acc[7:0]   <= cmd_rdata;
                            default: ;
                        endcase
                        if (r_byte_idx == 3'd5) begin
                            sample_data  <= {r_acc, cmd_rdata};
                            sample_valid <= 1'b1;
                            r_n          <= r_n - CNT_W'(1);
                            r_byte_idx   <= '0;
                        end else begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
